// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings and write FSM state type
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;
  localparam logic [3:0] CMD_PRECH = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_TRCD,
    S_WRITE,
    S_DATA,
    S_BSTOP,
    S_TWR,
    S_PRECH,
    S_TRP,
    S_END
  } state_t;

endpackage

// File: rtl/sdram_addr_ctr.sv
// rtl/sdram_addr_ctr.sv - latched {bank,row,col} write pointer with column and row stepping
module sdram_addr_ctr #(
  parameter int BA_W  = 2,
  parameter int ROW_W = 13,
  parameter int COL_W = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [BA_W+ROW_W+COL_W-1:0]  load_addr,
  input  logic                         col_inc,
  input  logic                         row_inc,
  output logic [BA_W-1:0]              ba,
  output logic [ROW_W-1:0]             row,
  output logic [COL_W-1:0]             col,
  output logic                         col_last
);

  localparam int BR_W = BA_W + ROW_W;

  logic [BR_W-1:0]  br_q, br_d;
  logic [COL_W-1:0] col_q, col_d;

  // Load wins; a row step carries into the bank and wraps at the top of memory
  always_comb begin
    br_d  = br_q;
    col_d = col_q;
    if (load) begin
      {br_d, col_d} = load_addr;
    end else if (row_inc) begin
      br_d  = br_q + BR_W'(1);
      col_d = '0;
    end else if (col_inc) begin
      col_d = col_q + COL_W'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q  <= '0;
      col_q <= '0;
    end else begin
      br_q  <= br_d;
      col_q <= col_d;
    end
  end

  assign ba       = br_q[BR_W-1 -: BA_W];
  assign row      = br_q[ROW_W-1:0];
  assign col      = col_q;
  assign col_last = &col_q;

endmodule

// File: rtl/sdram_write_burst.sv
// rtl/sdram_write_burst.sv - full-page SDRAM write engine with page-crossing bursts
module sdram_write_burst
  import sdram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int BA_W     = 2,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 9,
  parameter int LEN_W    = 10,
  parameter int TRCD_CYC = 2,
  parameter int TWR_CYC  = 2,
  parameter int TRP_CYC  = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        init_end,
  input  logic                        wr_en,
  input  logic [BA_W+ROW_W+COL_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]            wr_burst_len,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ack,
  output logic                        wr_end,
  output logic                        wr_busy,
  output logic [3:0]                  wr_cmd,
  output logic [BA_W-1:0]             wr_ba,
  output logic [ROW_W-1:0]            wr_sdram_addr,
  output logic                        wr_sdram_en,
  output logic [DATA_W-1:0]           wr_sdram_data
);

  localparam int CNT_W = 8;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [BA_W-1:0]    ba_q, ba_d;
  logic [ROW_W-1:0]   addr_q, addr_d;
  logic               ack_q, ack_d, end_q, end_d, busy_q, busy_d, en_q, en_d;

  logic               load, col_inc, row_inc, col_last;
  logic [BA_W-1:0]    ptr_ba;
  logic [ROW_W-1:0]   ptr_row;
  logic [COL_W-1:0]   ptr_col;

  sdram_addr_ctr #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W)) u_ptr (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .load      (load),
    .load_addr (wr_addr),
    .col_inc   (col_inc),
    .row_inc   (row_inc),
    .ba        (ptr_ba),
    .row       (ptr_row),
    .col       (ptr_col),
    .col_last  (col_last)
  );

  // Next state, remaining-word count, wait counter and pointer stepping
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    col_inc = 1'b0;
    row_inc = 1'b0;
    case (state_q)
      S_IDLE: if (wr_en && init_end) begin
        load    = 1'b1;
        rem_d   = wr_burst_len;
        state_d = (wr_burst_len == '0) ? S_END : S_ACT;
      end
      S_ACT: begin
        if (TRCD_CYC == 0) state_d = S_WRITE;
        else begin state_d = S_TRCD; cnt_d = CNT_W'(TRCD_CYC - 1); end
      end
      S_TRCD: begin
        if (cnt_q == '0) state_d = S_WRITE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_WRITE, S_DATA: begin
        // One word leaves per cycle; the row step is taken early so the pointer
        // already holds the next page when the following ACTIVE is decoded.
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1) || col_last) begin
          state_d = S_BSTOP;
          if (rem_q != LEN_W'(1)) row_inc = 1'b1;
        end else begin
          state_d = S_DATA;
          col_inc = 1'b1;
        end
      end
      S_BSTOP: begin
        if (TWR_CYC == 0) state_d = S_PRECH;
        else begin state_d = S_TWR; cnt_d = CNT_W'(TWR_CYC - 1); end
      end
      S_TWR: begin
        if (cnt_q == '0) state_d = S_PRECH;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_PRECH: begin
        if (TRP_CYC == 0) state_d = (rem_q != '0) ? S_ACT : S_END;
        else begin state_d = S_TRP; cnt_d = CNT_W'(TRP_CYC - 1); end
      end
      S_TRP: begin
        if (cnt_q == '0) state_d = (rem_q != '0) ? S_ACT : S_END;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with state_q
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = ba_q;
    addr_d = addr_q;
    ack_d  = 1'b0;
    en_d   = 1'b0;
    end_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_ACT: begin
        cmd_d = CMD_ACT;
        // Coming from IDLE the pointer loads on this same edge, so use the request
        if (state_q == S_IDLE) begin
          ba_d   = wr_addr[COL_W+ROW_W +: BA_W];
          addr_d = wr_addr[COL_W +: ROW_W];
        end else begin
          ba_d   = ptr_ba;
          addr_d = ptr_row;
        end
      end
      S_WRITE: begin
        cmd_d  = CMD_WRITE;
        ba_d   = ptr_ba;
        addr_d = ROW_W'(ptr_col);
        ack_d  = 1'b1;
        en_d   = 1'b1;
      end
      S_DATA: begin
        ack_d = 1'b1;
        en_d  = 1'b1;
      end
      S_BSTOP: cmd_d = CMD_BSTOP;
      S_PRECH: begin
        cmd_d      = CMD_PRECH;
        addr_d     = '0;
        addr_d[10] = 1'b1;
      end
      S_END:   end_d = 1'b1;
      default: ;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign wr_cmd        = cmd_q;
  assign wr_ba         = ba_q;
  assign wr_sdram_addr = addr_q;
  assign wr_ack        = ack_q;
  assign wr_end        = end_q;
  assign wr_busy       = busy_q;
  assign wr_sdram_en   = en_q;
  assign wr_sdram_data = wr_data;

endmodule

// File: tb/tb_sdram_write_burst.sv
// tb/tb_sdram_write_burst.sv - scoreboard bench with SDRAM bus model for sdram_write_burst
module tb_sdram_write_burst;

  localparam int TRCD = 2;
  localparam int TWR  = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic        wr_en = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [9:0]  wr_burst_len = '0;
  logic [15:0] wr_data;
  logic        wr_ack, wr_end, wr_busy, wr_sdram_en;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_sdram_addr;
  logic [15:0] wr_sdram_data;

  sdram_write_burst dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_burst_len  (wr_burst_len),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .wr_end        (wr_end),
    .wr_busy       (wr_busy),
    .wr_cmd        (wr_cmd),
    .wr_ba         (wr_ba),
    .wr_sdram_addr (wr_sdram_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [23:0] a; logic [15:0] d; } exp_t;
  typedef struct { logic [3:0] cmd; logic [1:0] ba; logic [12:0] addr; int cyc; } tr_t;
  typedef struct { logic [23:0] addr; logic [9:0] len; bit drop; int acts; } vec_t;

  exp_t        sb[$];
  tr_t         trace[$];
  vec_t        vecs[8];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, ack_cnt = 0, end_cnt = 0, stored_cnt = 0;
  int          src_idx = 0, push_idx = 0;
  bit          adv = 0;
  logic [12:0] open_row [4];
  logic [1:0]  cur_ba = '0;
  logic [8:0]  cur_col = '0;

  function automatic logic [15:0] dval(int i);
    return 16'(i * 37 + 4660);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Data source: moves to the next word after every acked cycle
  always @(posedge sys_clk) begin
    if (adv) begin
      adv = 0;
      #1;
      src_idx++;
      wr_data = dval(src_idx);
    end
  end

  // SDRAM bus model: tracks open rows, stores burst words, checks them against the scoreboard
  always @(negedge sys_clk) begin
    logic [23:0] ma;
    exp_t e;
    cyc++;
    if (!sys_rst) begin
      if (wr_cmd != 4'b0111) trace.push_back('{wr_cmd, wr_ba, wr_sdram_addr, cyc});
      if (wr_cmd == 4'b0011) open_row[wr_ba] = wr_sdram_addr;
      if (wr_cmd == 4'b0100) begin cur_ba = wr_ba; cur_col = wr_sdram_addr[8:0]; end
      if (wr_ack || wr_sdram_en) chk("ack_vs_en", 64'(wr_sdram_en), 64'(wr_ack));
      if (wr_sdram_en) begin
        ma = {cur_ba, open_row[cur_ba], cur_col};
        stored_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("word_addr_data", {ma, wr_sdram_data}, {e.a, e.d});
        end
        cur_col++;
      end
      if (wr_ack) begin ack_cnt++; adv = 1; end
      if (wr_end) end_cnt++;
    end
  end

  task automatic push_exp(input logic [23:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      sb.push_back('{a + 24'(i), dval(push_idx)});
      push_idx++;
    end
  endtask

  task automatic run_req(input logic [23:0] a, input logic [9:0] l, input bit drop,
                         input bit keep, input int acts);
    int t;
    logic [14:0] br;
    @(posedge sys_clk); #1;
    ack_cnt = 0; end_cnt = 0; stored_cnt = 0; trace.delete();
    wr_en = 1'b1; wr_addr = a; wr_burst_len = l;
    push_exp(a, int'(l));
    if (drop) begin @(posedge sys_clk); #1; wr_en = 1'b0; end
    t = 0;
    while (end_cnt == 0 && t < 5000) begin @(negedge sys_clk); #1; t++; end
    chk("end_timeout", 64'(t < 5000), 1);
    if (!keep) wr_en = 1'b0;
    chk("ack_count", 64'(ack_cnt), 64'(l));
    chk("stored_count", 64'(stored_cnt), 64'(l));
    chk("end_count", 64'(end_cnt), 1);
    chk("sb_drained", 64'(sb.size()), 0);
    chk("cmd_count", 64'(trace.size()), 64'(4 * acts));
    br = a[23:9];
    for (int k = 0; k < acts && trace.size() >= 4 * (k + 1); k++) begin
      chk("act_cmd",   64'(trace[4*k].cmd),   64'(4'b0011));
      chk("act_bank_row", {trace[4*k].ba, trace[4*k].addr}, 64'(br));
      chk("write_cmd", 64'(trace[4*k+1].cmd), 64'(4'b0100));
      chk("write_col", 64'(trace[4*k+1].addr), (k == 0) ? 64'(a[8:0]) : 64'(0));
      chk("trcd_gap",  64'(trace[4*k+1].cyc - trace[4*k].cyc), 64'(TRCD + 1));
      chk("bstop_cmd", 64'(trace[4*k+2].cmd), 64'(4'b0110));
      chk("prech_cmd", {trace[4*k+3].cmd, trace[4*k+3].addr[10]}, {4'b0010, 1'b1});
      chk("twr_gap",   64'(trace[4*k+3].cyc - trace[4*k+2].cyc), 64'(TWR + 1));
      br = br + 15'd1;
    end
    if (!keep) begin
      @(negedge sys_clk); #1;
      chk("busy_after_end", 64'(wr_busy), 0);
    end
  endtask

  initial begin
    int t;
    wr_data = dval(0);
    vecs[0] = '{24'h000000, 10'd10, 1'b0, 1};
    vecs[1] = '{{2'd0, 13'd5, 9'd510}, 10'd4, 1'b0, 2};
    vecs[2] = '{{2'd1, 13'd8191, 9'd511}, 10'd2, 1'b0, 2};
    vecs[3] = '{{2'd2, 13'd77, 9'd3}, 10'd0, 1'b0, 0};
    vecs[4] = '{{2'd3, 13'd8191, 9'd511}, 10'd3, 1'b0, 2};
    vecs[5] = '{{2'd1, 13'd300, 9'd100}, 10'd600, 1'b0, 2};
    vecs[6] = '{{2'd2, 13'd9, 9'd0}, 10'd1023, 1'b0, 2};
    vecs[7] = '{{2'd0, 13'd42, 9'd20}, 10'd5, 1'b1, 1};

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cmd",  64'(wr_cmd), 64'(4'b0111));
    chk("rst_outs", {wr_ba, wr_sdram_addr, wr_ack, wr_end, wr_busy, wr_sdram_en}, 0);
    sys_rst = 1'b0;

    // init_end low: request must be ignored
    wr_en = 1'b1; wr_addr = 24'h000010; wr_burst_len = 10'd3;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("no_accept_before_init", {wr_busy, 4'(trace.size())}, 0);
    wr_en = 1'b0;
    init_end = 1'b1;

    for (int v = 0; v < 8; v++)
      run_req(vecs[v].addr, vecs[v].len, vecs[v].drop, 1'b0, vecs[v].acts);

    // Back-to-back: second request accepted in the IDLE cycle right after END
    run_req({2'd1, 13'd7, 9'd509}, 10'd7, 1'b0, 1'b1, 2);
    run_req({2'd3, 13'd100, 9'd0}, 10'd5, 1'b0, 1'b0, 1);

    // Reset in the middle of the data phase
    @(posedge sys_clk); #1;
    ack_cnt = 0; end_cnt = 0; stored_cnt = 0; trace.delete();
    wr_en = 1'b1; wr_addr = {2'd2, 13'd11, 9'd40}; wr_burst_len = 10'd20;
    push_exp(wr_addr, 20);
    t = 0;
    while (ack_cnt < 5 && t < 200) begin @(posedge sys_clk); #3; t++; end
    chk("rst_wait_timeout", 64'(t < 200), 1);
    sys_rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("midrst_cmd", 64'(wr_cmd), 64'(4'b0111));
    chk("midrst_outs", {wr_sdram_en, wr_ack, wr_busy, wr_end}, 0);
    t = trace.size();
    chk("midrst_sb_left", 64'(sb.size()), 64'(20 - ack_cnt));
    chk("midrst_stored", 64'(stored_cnt), 64'(ack_cnt));
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (8) @(posedge sys_clk);
    #1;
    chk("no_cmd_after_rst", 64'(trace.size()), 64'(t));
    sb.delete();
    push_idx = src_idx;

    run_req({2'd0, 13'd1, 9'd511}, 10'd3, 1'b0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
